intr_controller: RTL
====================

Name: intr_controller

Overview:
- Multi-source interrupt controller and the initiator side of the control unit's interrupt handshake.
- Synchronises external interrupt lines, edge-detects them and holds them as pending bits. Arbitrates among pending, unmasked sources and drives the registered `intr` request to the control unit.
- Clears the serviced source on the control unit's `int_clr`, then blocks new requests until the handler completes (`in_service`/Int_en high then low, i.e. RTI).
- Sits between the I/O pins and the fetch-stage control logic.

Parameters:
- NUM_SRC, 4, number of interrupt sources (2..8).
- ID_W, 2, width of irq_id; must satisfy 2^ID_W >= NUM_SRC.
- SYNC_STAGES, 2, synchroniser flops per source (>=2).
- SVC_TIMEOUT, 15, cycles allowed in SVC_WAIT for in_service to rise; 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- irq_in  in  NUM_SRC  raw asynchronous interrupt lines, rising-edge triggered.
- irq_mask  in  NUM_SRC  1 = source enabled for arbitration.
- int_clr  in  1  ack pulse from control unit: request accepted.
- in_service  in  1  Int_en from control unit; high while the handler runs.
- intr  out  1  registered interrupt request to control unit.
- irq_id  out  ID_W  index of granted source; valid while intr=1 and until return to IDLE.
- pending  out  NUM_SRC  current pending bits.
- busy  out  1  1 when state != IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, sync chains 0, edge-history register 0, pending 0, timeout counter 0.
- A line already high at reset release produces exactly one edge after SYNC_STAGES+1 cycles.
- Synchronisation and edges:
  - Each irq_in bit passes through SYNC_STAGES flops.
  - Edge = sync & ~prev.
  - An edge sets pending[i] regardless of the mask. The mask only gates arbitration, so masked edges are retained.
- Latency: raw rising edge to intr=1 is SYNC_STAGES+2 cycles when in IDLE (sync, edge/pending, grant register).
- States:
  - IDLE:
    - If in_service=0 and (pending & irq_mask) != 0: register irq_id = winner, intr <= 1, go REQ.
    - Fixed priority: lowest index wins.
    - If in_service=1, stay in IDLE; no nesting.
  - REQ:
    - intr held 1, irq_id stable.
    - On int_clr=1: intr <= 0, clear pending[irq_id], zero the counter, go SVC_WAIT.
    - The grant is not withdrawn if irq_mask changes while in REQ.
  - SVC_WAIT:
    - If in_service=1: go SVC.
    - Else count. If SVC_TIMEOUT != 0 and the count reaches SVC_TIMEOUT, go IDLE (lost service, no retry).
  - SVC: wait for in_service=0, then go IDLE.
- Re-arbitration: the earliest new intr is 1 cycle after returning to IDLE.
- Simultaneous events:
  - A new edge on source irq_id in the same cycle as int_clr leaves pending[irq_id]=1 (set wins over clear).
  - Edges on other sources always set their bits.
- int_clr while in IDLE, SVC_WAIT or SVC is ignored.
- in_service already high on entry to SVC_WAIT moves to SVC the next cycle.
- Width: the counter is wide enough for SVC_TIMEOUT and saturates. irq_id is zero-extended.
- Reset asserted mid-handshake: immediately returns to the reset values. Any in-flight request is dropped.

Optional Feature:
- Macro: INTC_ROUND_ROBIN_EN.
- Defined:
  - Arbitration is round-robin. A last-grant pointer (reset 0, so the first search starts at source 1) updates on each int_clr in REQ.
  - Search starts at pointer+1, wrapping modulo NUM_SRC.
- Undefined: fixed priority, lowest index wins; the pointer register is not built.

Test Plan:
- Single source: rst release, irq_mask=4'b1111, pulse irq_in[2] -> intr=1, irq_id=2 exactly 4 cycles after the edge (SYNC_STAGES=2). int_clr pulse -> intr=0, pending[2]=0. in_service 1 then 0 -> busy=0.
- Priority: raise irq_in[3] and irq_in[1] in the same cycle -> first grant irq_id=1. After full service, second grant irq_id=3. With INTC_ROUND_ROBIN_EN and pointer=1, third raise of both -> irq_id=3.
- Masking: irq_mask=4'b0000, edge on irq_in[0] -> intr stays 0, pending=4'b0001. Set irq_mask[0]=1 -> intr=1, irq_id=0 the next cycle.
- No nesting: in_service=1 while in IDLE, edge on irq_in[1] -> intr stays 0. in_service=0 -> intr=1, irq_id=1 one cycle later.
- Set-wins collision: in REQ with irq_id=0, new edge on source 0 in the same cycle as int_clr -> pending[0]=1 after the clock. Re-requested once back in IDLE.
- Timeout and reset: int_clr with in_service never rising -> busy=0 after 15 cycles. Assert rst while intr=1 -> intr, pending, busy=0 asynchronously.

Source files
------------

// File: rtl/intr_controller.sv
// intr_controller: synchronised, edge-latched interrupt sources arbitrated into an intr/int_clr/in_service handshake.
// Define INTC_ROUND_ROBIN_EN for round-robin arbitration instead of fixed lowest-index priority.
module intr_controller #(
  parameter int NUM_SRC     = 4,
  parameter int ID_W        = 2,
  parameter int SYNC_STAGES = 2,
  parameter int SVC_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic [NUM_SRC-1:0] irq_mask,
  input  logic               int_clr,
  input  logic               in_service,
  output logic               intr,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_SRC-1:0] pending,
  output logic               busy
);
  localparam int CW = SVC_TIMEOUT > 0 ? $clog2(SVC_TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, REQ, SVC_WAIT, SVC} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync;
  logic [NUM_SRC-1:0] prev, edges, req, clr;
  logic [ID_W-1:0] win;
  logic [CW-1:0] cnt, cnt_nxt;
  logic ack;
  assign busy    = state != IDLE;
  assign edges   = sync[SYNC_STAGES-1] & ~prev;
  assign req     = pending & irq_mask;
  assign ack     = state == REQ && int_clr;
  assign clr     = ack ? NUM_SRC'(1) << irq_id : '0;
  assign cnt_nxt = &cnt ? cnt : cnt + CW'(1);
`ifdef INTC_ROUND_ROBIN_EN
  logic [ID_W-1:0] ptr;
  logic [NUM_SRC-1:0] rot;
  // Rotate so the source after the last grant sits at bit 0, then take the lowest set bit.
  assign rot = NUM_SRC'({req, req} >> ((ID_W+1)'(ptr) + (ID_W+1)'(1)));
  always_comb begin
    win = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) if (rot[k]) win = ID_W'((int'(ptr) + 1 + k) % NUM_SRC);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) ptr <= '0;
    else if (ack) ptr <= irq_id;
`else
  always_comb begin
    win = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) if (req[k]) win = ID_W'(k);
  end
`endif
  // A fresh edge on the source being cleared survives: set wins over clear.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sync    <= '0;
      prev    <= '0;
      pending <= '0;
      state   <= IDLE;
      intr    <= 1'b0;
      irq_id  <= '0;
      cnt     <= '0;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], irq_in};
      prev    <= sync[SYNC_STAGES-1];
      pending <= (pending & ~clr) | edges;
      case (state)
        IDLE: if (!in_service && |req) begin
          irq_id <= win;
          intr   <= 1'b1;
          state  <= REQ;
        end
        REQ: if (int_clr) begin
          intr  <= 1'b0;
          cnt   <= '0;
          state <= SVC_WAIT;
        end
        SVC_WAIT: if (in_service) state <= SVC;
        else begin
          cnt <= cnt_nxt;
          if (SVC_TIMEOUT != 0 && cnt_nxt == CW'(SVC_TIMEOUT)) state <= IDLE;
        end
        default: if (!in_service) state <= IDLE;
      endcase
    end
endmodule
